// File: rtl/sm_ram_loader_pkg.sv
// Shared definitions for the RAM boot loader: FSM state encoding and word geometry.
package sm_ram_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/sm_loader_packer.sv
// Byte-to-word packer: places each accepted byte into its little-endian lane of
// a 32-bit word and flags the load that completes the word.
module sm_loader_packer
  import sm_ram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        full
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      word_q, word_d;

  // Next lane index and word contents; clear wins over load.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_data;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;
  assign full = load && !clr && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/sm_ram_loader.sv
// Boot loader bus initiator: packs a byte stream into words and writes them to
// consecutive RAM word addresses.
// Optional feature macro: SM_LOADER_VERIFY_EN adds a readback cycle per word and
// a sticky mismatch flag on err; without it err is 0 and rd is ignored.
module sm_ram_loader
  import sm_ram_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [CNT_W-1:0] count,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      a,
  output logic             we,
  output logic [31:0]      wd,
  input  logic [31:0]      rd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             word_done;
  logic             pack_clr;
  logic             pack_load;
  logic             pack_full;
  logic [31:0]      pack_word;
`ifdef SM_LOADER_VERIFY_EN
  logic             err_q, err_d;
`endif

  sm_loader_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .load      (pack_load),
    .byte_data (byte_data),
    .word      (pack_word),
    .full      (pack_full)
  );

  // Next-state, address/counter update and bus outputs. The address only
  // advances when another word follows, so DONE shows the last written address.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_done   = 1'b0;
    pack_clr    = 1'b0;
    pack_load   = 1'b0;
    byte_ready  = 1'b0;
    we          = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
`ifdef SM_LOADER_VERIFY_EN
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          addr_d      = {base[31:2], 2'b00};
          remaining_d = count;
          pack_clr    = 1'b1;
`ifdef SM_LOADER_VERIFY_EN
          err_d       = 1'b0;
`endif
          state_d     = (count == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        byte_ready = 1'b1;
        pack_load  = byte_valid;
        if (pack_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        we = 1'b1;
`ifdef SM_LOADER_VERIFY_EN
        state_d = ST_VERIFY;
`else
        word_done = 1'b1;
`endif
      end
`ifdef SM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        if (rd != pack_word) err_d = 1'b1;
        word_done = 1'b1;
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (word_done) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_COLLECT;
        addr_d  = addr_q + 32'd4;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

`ifdef SM_LOADER_VERIFY_EN
  // Sticky readback mismatch flag, cleared by a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_rd;
  assign unused_rd = ^rd;
  assign err       = 1'b0;
`endif

  assign a  = addr_q;
  assign wd = pack_word;

endmodule
